// File: rtl/freq_meter_if.sv
// freq_meter_if: enable/signal inputs and measurement results of freq_meter.
`default_nettype none

interface freq_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_count;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output enable,
    output sig_in,
    input  freq_count,
    input  valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  enable,
    input  sig_in,
    output freq_count,
    output valid,
    output overflow,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over back-to-back GATE_CYCLES windows.
// Rev 1.0 - initial release.
`default_nettype none

module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  freq_meter_if.slave bus
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    C_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CMAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;

  logic             w_edge;
  logic             w_sat;
  logic [CNT_W-1:0] w_edge_next;
  logic             w_ovf_next;

  // Count including this cycle's edge, so the final cycle's edge lands in the ending window.
  assign w_edge      = r_sync2 & ~r_hist;
  assign w_sat       = (r_edge_cnt == C_CMAX);
  assign w_edge_next = (w_edge && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_next  = r_ovf | (w_edge & w_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_hist         <= 1'b0;
      r_gate_cnt     <= '0;
      r_edge_cnt     <= '0;
      r_ovf          <= 1'b0;
      bus.freq_count <= '0;
      bus.valid      <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      r_sync1   <= bus.sig_in;
      r_sync2   <= r_sync1;
      r_hist    <= r_sync2;
      bus.valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_ovf      <= 1'b0;
          if (bus.enable) begin
            r_state  <= MEASURE;
            bus.busy <= 1'b1;
          end
        end
        MEASURE: begin
          if (!bus.enable) begin
            r_state    <= IDLE;
            bus.busy   <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end else if (r_gate_cnt == C_LAST) begin
            bus.freq_count <= w_edge_next;
            bus.overflow   <= w_ovf_next;
            bus.valid      <= 1'b1;
            r_gate_cnt     <= '0;
            r_edge_cnt     <= '0;
            r_ovf          <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_edge_next;
            r_ovf      <= w_ovf_next;
          end
        end
        default: begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter with GATE_CYCLES=100 (CNT_W=8 and CNT_W=4 instances).
`default_nettype none

module tb_freq_meter;

  logic clk;
  logic rst;

  freq_meter_if #(.CNT_W(8)) bus8 ();
  freq_meter_if #(.CNT_W(4)) bus4 ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   r_per    = 0;
  int   r_phase  = 0;
  logic r_lvl    = 1'b0;
  logic r_stray  = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // r_per==0 holds sig_in at r_lvl; otherwise a square wave with one rise per period.
  task automatic drive_sig();
    logic s;
    if (r_per == 0) s = r_lvl;
    else            s = ((r_phase % r_per) >= (r_per / 2));
    bus4.sig_in = s;
    bus8.sig_in = s;
  endtask

  task automatic set_mode(input int per, input logic lvl);
    r_per   = per;
    r_lvl   = lvl;
    r_phase = 0;
    drive_sig();
  endtask

  task automatic tick();
    @(negedge clk);
    r_phase++;
    drive_sig();
  endtask

  task automatic measure(input int per, input logic lvl, input int e_cnt, input int e_ovf,
                         input string tag);
    bus4.enable = 1'b0;
    set_mode(per, lvl);
    repeat (5) tick();
    bus4.enable = 1'b1;
    r_stray = 1'b0;
    for (int t = 1; t <= 101; t++) begin
      tick();
      if (t == 1) check_val({tag, "_busy"}, bus4.busy, 1);
      if (t < 101) r_stray |= bus4.valid;
    end
    check_val({tag, "_stray"}, r_stray, 0);
    check_val({tag, "_valid"}, bus4.valid, 1);
    check_val({tag, "_cnt"}, bus4.freq_count, e_cnt);
    check_val({tag, "_ovf"}, bus4.overflow, e_ovf);
    tick();
    check_val({tag, "_pulse"}, bus4.valid, 0);
  endtask

  task automatic step_test(input int at, input int e1, input int e2, input string tag);
    bus4.enable = 1'b0;
    set_mode(0, 1'b0);
    repeat (5) tick();
    bus4.enable = 1'b1;
    r_stray = 1'b0;
    for (int t = 1; t <= 201; t++) begin
      tick();
      if (t == 101) begin
        check_val({tag, "_v1"}, bus4.valid, 1);
        check_val({tag, "_c1"}, bus4.freq_count, e1);
      end else if (t == 201) begin
        check_val({tag, "_v2"}, bus4.valid, 1);
        check_val({tag, "_c2"}, bus4.freq_count, e2);
        check_val({tag, "_o2"}, bus4.overflow, 0);
      end else begin
        r_stray |= bus4.valid;
      end
      if (t == at) set_mode(0, 1'b1);
    end
    check_val({tag, "_stray"}, r_stray, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus4.enable = 1'b0;
    bus8.enable = 1'b0;
    set_mode(0, 1'b0);
    repeat (3) tick();
    check_val("rst_cnt4", bus4.freq_count, 0);
    check_val("rst_valid4", bus4.valid, 0);
    check_val("rst_ovf4", bus4.overflow, 0);
    check_val("rst_busy4", bus4.busy, 0);
    check_val("rst_cnt8", bus8.freq_count, 0);
    check_val("rst_busy8", bus8.busy, 0);
    rst = 1'b0;
    tick();

    // Wide counter: three contiguous windows of a period-10 signal.
    set_mode(10, 1'b0);
    repeat (5) tick();
    bus8.enable = 1'b1;
    r_stray = 1'b0;
    for (int t = 1; t <= 301; t++) begin
      tick();
      if (t == 1) check_val("p10w_busy", bus8.busy, 1);
      if (t > 1 && (t % 100) == 1) begin
        check_val("p10w_valid", bus8.valid, 1);
        check_val("p10w_cnt", bus8.freq_count, 10);
        check_val("p10w_ovf", bus8.overflow, 0);
      end else begin
        r_stray |= bus8.valid;
      end
    end
    check_val("p10w_stray", r_stray, 0);
    bus8.enable = 1'b0;

    measure(4, 1'b0, 15, 1, "p4_sat");
    measure(20, 1'b0, 5, 0, "p20");
    measure(0, 1'b0, 0, 0, "const0");
    measure(0, 1'b1, 0, 0, "const1");
    step_test(30, 1, 0, "step");
    step_test(98, 1, 0, "edge_last");
    step_test(99, 0, 1, "edge_next");
    measure(10, 1'b0, 10, 0, "p10");

    // Abort at gate_cnt=50 with a pattern that would otherwise saturate.
    bus4.enable = 1'b0;
    set_mode(4, 1'b0);
    repeat (5) tick();
    bus4.enable = 1'b1;
    repeat (51) tick();
    bus4.enable = 1'b0;
    tick();
    check_val("ab50_busy", bus4.busy, 0);
    check_val("ab50_valid", bus4.valid, 0);
    r_stray = 1'b0;
    repeat (60) begin
      tick();
      r_stray |= bus4.valid;
    end
    check_val("ab50_stray", r_stray, 0);
    check_val("ab50_cnt", bus4.freq_count, 10);
    check_val("ab50_ovf", bus4.overflow, 0);

    // Abort on the final window cycle.
    bus4.enable = 1'b1;
    repeat (100) tick();
    bus4.enable = 1'b0;
    tick();
    check_val("ab99_valid", bus4.valid, 0);
    check_val("ab99_busy", bus4.busy, 0);
    check_val("ab99_cnt", bus4.freq_count, 10);
    check_val("ab99_ovf", bus4.overflow, 0);

    // Reset mid-window at gate_cnt=70, then a full window after re-entry.
    set_mode(0, 1'b0);
    repeat (5) tick();
    bus4.enable = 1'b1;
    repeat (71) tick();
    rst = 1'b1;
    tick();
    check_val("rst70_cnt", bus4.freq_count, 0);
    check_val("rst70_valid", bus4.valid, 0);
    check_val("rst70_ovf", bus4.overflow, 0);
    check_val("rst70_busy", bus4.busy, 0);
    rst = 1'b0;
    r_stray = 1'b0;
    for (int t = 73; t <= 173; t++) begin
      tick();
      if (t == 73) check_val("rst70_reentry", bus4.busy, 1);
      if (t < 173) r_stray |= bus4.valid;
      if (t == 120) set_mode(0, 1'b1);
    end
    check_val("rst70_stray", r_stray, 0);
    check_val("rst70_valid2", bus4.valid, 1);
    check_val("rst70_cnt2", bus4.freq_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, giving the measurement window length in clk cycles; legal range is 2 or more.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the edge-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: level high runs back-to-back measurement windows.
REQ-006 The block SHALL have port sig_in, input, 1 bit: the signal to be measured, asynchronous to clk.
REQ-007 The block SHALL have port freq_count, output, CNT_W bits: rising edges counted in the last completed window.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse when freq_count/overflow update.
REQ-009 The block SHALL have port overflow, output, 1 bit: the last completed window saturated.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in MEASURE.

Function
REQ-011 The block SHALL pass sig_in through a 2-flop synchronizer plus one history flop; a detected edge is sync=1 with history=0.
REQ-012 A sig_in rising edge SHALL appear as an edge 3 clk later; this pipeline SHALL run in all states.
REQ-013 The FSM SHALL have exactly two states, IDLE and MEASURE.
REQ-014 IDLE SHALL go to MEASURE on the cycle after enable is sampled high.
REQ-015 On IDLE-to-MEASURE entry, gate_cnt and edge_cnt SHALL be cleared.
REQ-016 In MEASURE, gate_cnt SHALL count 0..GATE_CYCLES-1, one step per clk.
REQ-017 gate_cnt SHALL be $clog2(GATE_CYCLES) bits wide, minimum 1.
REQ-018 In MEASURE, edge_cnt SHALL add 1 per detected edge.
REQ-019 edge_cnt SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set an internal ovf flag.
REQ-020 The final window cycle SHALL be the MEASURE cycle with gate_cnt==GATE_CYCLES-1 and enable high.
REQ-021 On the final window cycle, freq_count SHALL load edge_cnt plus that cycle's edge, saturated.
REQ-022 On the final window cycle, overflow SHALL load ovf, set by that cycle's edge if it saturates.
REQ-023 valid SHALL be 1 on the cycle after the final window cycle and 0 otherwise.
REQ-024 On the final window cycle, gate_cnt, edge_cnt and ovf SHALL clear and the FSM SHALL stay in MEASURE.
REQ-025 Windows SHALL be contiguous, exactly GATE_CYCLES clk long, with every edge counted in exactly one window.
REQ-026 Abort: enable low in any MEASURE cycle, including the final one, SHALL send the FSM to IDLE next cycle.
REQ-027 On abort, counters SHALL clear, no valid SHALL be produced, and freq_count/overflow SHALL hold their previous values.
REQ-028 Edges detected in IDLE SHALL be ignored.
REQ-029 freq_count and overflow SHALL hold between valid pulses.
REQ-030 busy SHALL be registered and equal to (state==MEASURE).
REQ-031 valid SHALL be registered and freq_count/overflow registered outputs; outputs SHALL have no combinational path from inputs.

Reset
REQ-032 rst high on a clk edge SHALL set state=IDLE.
REQ-033 rst SHALL set freq_count=0, valid=0, overflow=0 and busy=0.
REQ-034 rst SHALL clear gate_cnt, edge_cnt, ovf, the synchronizer flops and the history flop.
REQ-035 rst SHALL take priority over enable and the window logic, including mid-window, and SHALL discard any partial count with no valid.
REQ-036 The first MEASURE cycle after reset release SHALL be no earlier than the second clk after rst falls with enable high.

Verification (GATE_CYCLES=100, CNT_W=4 unless stated)
REQ-037 Bench SHALL drive enable high with sig_in period 10 clk and CNT_W=8 -> valid every 100 clk after the first, freq_count=10, overflow=0.
REQ-038 Bench SHALL drive sig_in period 4 clk -> 25 edges, so freq_count=15, overflow=1; then period 20 -> next valid gives freq_count=5, overflow=0.
REQ-039 Bench SHALL hold sig_in constant 0, then constant 1 -> each valid gives freq_count=0; a single 0-to-1 step is counted once.
REQ-040 Bench SHALL drop enable at gate_cnt=50, then at gate_cnt=99 -> no valid, busy low next cycle, freq_count holds the prior value.
REQ-041 Bench SHALL assert rst for 1 cycle at gate_cnt=70 -> all outputs 0 next cycle; the next valid arrives 100 MEASURE cycles after re-entry.
REQ-042 Bench SHALL place a sig_in edge so it is detected on the final window cycle -> it is counted in the ending window, not the next.
